// File: rtl/kernel_interpolator.sv
// Sequential kernel interpolator: blends identity and a selected N-tap kernel one tap per cycle,
// committing all taps at once. Optional strength slew is enabled by defining KERNEL_SLEW_EN.
module kernel_interpolator #(
    parameter int N         = 25,
    parameter int BW        = 16,
    parameter int FRAC_BITS = 8,
    parameter int K_RANGE   = 16,
    parameter int OUT_W     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(K_RANGE):0]      k_index,
    input  logic [N-1:0][BW-1:0]          kernel_in,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(K_RANGE):0]      k_active,
    output logic [N-1:0][OUT_W-1:0]       kernel_out,
    output logic [1:0]                    state_dbg
);
    localparam int KW    = $clog2(K_RANGE) + 1;
    localparam int TW    = (N > 1) ? $clog2(N) : 1;
    localparam int SCALE = 1 << FRAC_BITS;
    localparam logic signed [OUT_W-1:0] K_DIV = OUT_W'(K_RANGE);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [TW-1:0]             tap_q, tap_d;
    logic [KW-1:0]             k_eff_q, k_eff_d;
    logic [KW-1:0]             k_active_q, k_active_d;
    logic                      done_q, done_d;
    logic [N-1:0][BW-1:0]      in_buf_q;
    logic [N-1:0][OUT_W-1:0]   shadow_q;
    logic [N-1:0][OUT_W-1:0]   kout_q;

    logic [KW-1:0]             k_clamp;
    logic [KW-1:0]             k_target;
    logic                      accept;

    logic signed [OUT_W-1:0]   tap_in, id_val, range_v, scaled, quot, tap_val;

    assign accept  = (state_q == S_IDLE) && start;
    assign k_clamp = (k_index > KW'(K_RANGE)) ? KW'(K_RANGE) : k_index;

`ifdef KERNEL_SLEW_EN
    logic [KW-1:0] k_cur_q;

    // Strength moves at most one step toward the request per committed kernel.
    always_comb begin
        k_target = k_cur_q;
        if (k_clamp > k_cur_q) begin
            k_target = k_cur_q + KW'(1);
        end else if (k_clamp < k_cur_q) begin
            k_target = k_cur_q - KW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_cur_q <= '0;
        end else if (state_q == S_COMMIT) begin
            k_cur_q <= k_eff_q;
        end
    end
`else
    assign k_target = k_clamp;
`endif

    // Shared datapath: ((range*SCALE)/K_RANGE)*k_eff + id*SCALE, signed, truncating division.
    always_comb begin
        tap_in  = OUT_W'(signed'(in_buf_q[tap_q]));
        id_val  = (tap_q == TW'(N / 2)) ? OUT_W'(1) : '0;
        range_v = tap_in - id_val;
        scaled  = range_v <<< FRAC_BITS;
        quot    = scaled / K_DIV;
        tap_val = quot * signed'(OUT_W'(k_eff_q)) + (id_val <<< FRAC_BITS);
    end

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        k_eff_d    = k_eff_q;
        k_active_d = k_active_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    tap_d   = '0;
                    k_eff_d = k_target;
                end
            end
            S_CALC: begin
                tap_d = tap_q + TW'(1);
                if (tap_q == TW'(N - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d    = S_IDLE;
                done_d     = 1'b1;
                k_active_d = k_eff_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tap_q      <= '0;
            k_eff_q    <= '0;
            k_active_q <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                kout_q[i] <= (i == N / 2) ? OUT_W'(SCALE) : '0;
            end
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            k_eff_q    <= k_eff_d;
            k_active_q <= k_active_d;
            done_q     <= done_d;
            if (state_q == S_COMMIT) begin
                kout_q <= shadow_q;
            end
        end
    end

    // Input buffer and shadow hold don't-care contents outside a calculation.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            in_buf_q <= kernel_in;
        end
        if (!reset && state_q == S_CALC) begin
            shadow_q[tap_q] <= tap_val;
        end
    end

    assign busy       = (state_q == S_CALC) || (state_q == S_COMMIT);
    assign done       = done_q;
    assign k_active   = k_active_q;
    assign kernel_out = kout_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_kernel_interpolator.sv
// Self-checking bench for kernel_interpolator: vector table, scoreboard queue, corner sequences.
module tb_kernel_interpolator;
    localparam int N  = 25;
    localparam int BW = 16;
    localparam int OW = 32;
    localparam int KR = 16;
    localparam int KW = 5;

    typedef logic [N-1:0][BW-1:0] kin_t;
    typedef logic [N-1:0][OW-1:0] kout_t;

    typedef struct {
        int fill;
        int t0;
        int kidx;
        int e_other;
        int e_center;
        int e_t0;
        int e_k;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_idx = '0;
    kin_t          kin = '0;
    logic          busy, done;
    logic [KW-1:0] k_active;
    kout_t         kout;
    logic [1:0]    state_dbg;

    // Second instance with a non-power-of-two range to exercise truncation.
    logic             b_start = 1'b0;
    logic [4:0]       b_k_idx = '0;
    logic [4:0][15:0] b_kin = '0;
    logic             b_busy, b_done;
    logic [4:0]       b_k_active;
    logic [4:0][31:0] b_kout;
    logic [1:0]       b_state_dbg;

    int checks = 0;
    int errors = 0;
    int m_kcur = 0;

    logic [N*OW-1:0] exp_q[$];
    int              kexp_q[$];

    vec_t vecs[7];

    kernel_interpolator #(.N(N), .BW(BW), .FRAC_BITS(8), .K_RANGE(KR), .OUT_W(OW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_index(k_idx), .kernel_in(kin),
        .busy(busy), .done(done), .k_active(k_active), .kernel_out(kout), .state_dbg(state_dbg)
    );

    kernel_interpolator #(.N(5), .BW(16), .FRAC_BITS(8), .K_RANGE(12), .OUT_W(32)) dut12 (
        .clk(clk), .reset(reset), .start(b_start), .k_index(b_k_idx), .kernel_in(b_kin),
        .busy(b_busy), .done(b_done), .k_active(b_k_active), .kernel_out(b_kout),
        .state_dbg(b_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_kernel(input string name, input logic [N*OW-1:0] act,
                                input logic [N*OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int j = 0; j < N; j++) begin
                if (act[j*OW +: OW] !== exp[j*OW +: OW]) begin
                    $display("FAIL %s: tap %0d got %0d expected %0d", name, j,
                             $signed(act[j*OW +: OW]), $signed(exp[j*OW +: OW]));
                    break;
                end
            end
        end
    endtask

    function automatic int clamp_k(input int k);
        return (k > KR) ? KR : k;
    endfunction

    function automatic int model_keff(input int kidx);
        int c;
        c = clamp_k(kidx);
`ifdef KERNEL_SLEW_EN
        if (c > m_kcur) return m_kcur + 1;
        if (c < m_kcur) return m_kcur - 1;
        return m_kcur;
`else
        return c;
`endif
    endfunction

    function automatic logic [N*OW-1:0] model_kernel(input kin_t k, input int keff);
        logic [N*OW-1:0] r;
        int id, rg, v;
        for (int j = 0; j < N; j++) begin
            id = (j == N / 2) ? 1 : 0;
            rg = int'($signed(k[j])) - id;
            v  = ((rg * 256) / KR) * keff + id * 256;
            r[j*OW +: OW] = v;
        end
        return r;
    endfunction

    function automatic logic [N*OW-1:0] identity_kernel();
        logic [N*OW-1:0] r;
        r = '0;
        r[(N/2)*OW +: OW] = 256;
        return r;
    endfunction

    function automatic kin_t make_kin(input int fill, input int t0);
        kin_t k;
        for (int j = 0; j < N; j++) k[j] = BW'(fill);
        k[0] = BW'(t0);
        return k;
    endfunction

    // Called at a negedge; leaves the bench at the negedge right after the accepting edge.
    task automatic drive_start(input kin_t k, input int kidx);
        int keff;
        kin   = k;
        k_idx = KW'(kidx);
        start = 1'b1;
        keff  = model_keff(kidx);
        m_kcur = keff;
        exp_q.push_back(model_kernel(k, keff));
        kexp_q.push_back(keff);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_output();
        logic [N*OW-1:0] e;
        int ek;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e  = exp_q.pop_front();
        ek = kexp_q.pop_front();
        check_kernel("kernel_out", kout, e);
        check("k_active", int'(k_active), ek);
        check("busy_in_done", int'(busy), 0);
    endtask

    task automatic run_kernel(input kin_t k, input int kidx);
        int lat;
        drive_start(k, kidx);
        wait_done(lat);
        check("latency", lat, N + 1);
        check_output();
    endtask

    initial begin
        int lat, ndone, nchg, d12;
        kout_t prev;

        vecs[0] = '{1, 1, 16, 256, 256, 256, 16};
        vecs[1] = '{1, 1, 8, 128, 256, 128, 8};
        vecs[2] = '{1, -1, 8, 128, 256, -128, 8};
        vecs[3] = '{3, -5, 20, 768, 768, -1280, 16};
        vecs[4] = '{0, 7, 0, 0, 256, 0, 0};
        vecs[5] = '{-32768, 32767, 16, -8388608, -8388608, 8388352, 16};
        vecs[6] = '{5, 3, 3, 240, 448, 144, 3};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_k_active", int'(k_active), 0);
        check_kernel("rst_kernel_out", kout, identity_kernel());

        for (int i = 0; i < 7; i++) begin
            run_kernel(make_kin(vecs[i].fill, vecs[i].t0), vecs[i].kidx);
`ifndef KERNEL_SLEW_EN
            check("vec_other", int'($signed(kout[1])), vecs[i].e_other);
            check("vec_center", int'($signed(kout[N/2])), vecs[i].e_center);
            check("vec_tap0", int'($signed(kout[0])), vecs[i].e_t0);
            check("vec_k_active", int'(k_active), vecs[i].e_k);
`endif
            @(posedge clk);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
        end

        for (int i = 0; i < 4; i++) begin
            kin_t rk;
            for (int j = 0; j < N; j++) rk[j] = BW'($urandom_range(0, 65535));
            run_kernel(rk, $urandom_range(0, 20));
            @(negedge clk);
        end

        // Back-to-back: restart in the done cycle.
        drive_start(make_kin(2, 9), 5);
        wait_done(lat);
        check("b2b_latency_a", lat, N + 1);
        check_output();
        drive_start(make_kin(-4, 11), 12);
        check("b2b_done_dropped", int'(done), 0);
        wait_done(lat);
        check("b2b_latency_b", lat, N + 1);
        check_output();
        @(negedge clk);

        // Start pulsed mid-calculation with new inputs must be ignored.
        prev = kout;
        drive_start(make_kin(2, -3), 8);
        lat = 0; ndone = 0; nchg = 0;
        while (!done && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1; k_idx = KW'(16); kin = make_kin(7, 7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (!done && kout !== prev) nchg++;
        end
        start = 1'b0;
        check("ign_latency", lat, N + 1);
        check("ign_early_change", nchg, 0);
        check_output();
        repeat (N + 3) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        check("ign_extra_done", ndone, 0);

        // Reset in the middle of CALC discards the partial kernel.
        drive_start(make_kin(1, 1), 16);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        void'(exp_q.pop_back());
        void'(kexp_q.pop_back());
        m_kcur = 0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_k_active", int'(k_active), 0);
        check_kernel("midrst_kernel_out", kout, identity_kernel());
        ndone = 0;
        repeat (N + 3) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        reset = 1'b1; start = 1'b1; k_idx = KW'(16);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_start_ignored", int'(busy), 0);
        run_kernel(make_kin(1, 1), 16);
        @(negedge clk);

`ifdef KERNEL_SLEW_EN
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_kcur = 0;
        run_kernel(make_kin(1, 1), 16);
        check("slew_step1", int'(k_active), 1);
        run_kernel(make_kin(1, 1), 16);
        check("slew_step2", int'(k_active), 2);
        run_kernel(make_kin(1, 1), 16);
        check("slew_step3", int'(k_active), 3);
        run_kernel(make_kin(1, 1), 0);
        check("slew_down", int'(k_active), 2);
`else
        for (int pass = 0; pass < 2; pass++) begin
            b_kin = '0;
            b_kin[0] = 16'd1;
            b_k_idx = (pass == 0) ? 5'd12 : 5'd20;
            b_start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            b_start = 1'b0;
            d12 = 0;
            while (!b_done && d12 < 100) begin
                @(posedge clk);
                @(negedge clk);
                d12++;
            end
            check("k12_latency", d12, 6);
            check("k12_tap0", int'($signed(b_kout[0])), 252);
            check("k12_center", int'($signed(b_kout[2])), 4);
            check("k12_tap1", int'($signed(b_kout[1])), 0);
            check("k12_k_active", int'(b_k_active), 12);
            @(negedge clk);
        end
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
